mmu_feeder: RTL and testbench
=============================

Name: mmu_feeder

Overview:
- Sequencer that drives the 2x2 systolic array input side: `load_weight`, `weight1..4`, `valid`, `a_in1`, `a_in2`.
- Captures a 2x2 weight set on `start`, pulses `load_weight`, then accepts activation row-pairs over a valid/ready stream.
- Emits the rows with the diagonal skew the array needs: lane 2 lags lane 1 by one cycle.
- Signals completion after the skew has drained. Sits between the activation buffer and the MMU top level.

Parameters:
- DATA_W, 16, width of activations and weights
- CNT_W, 8, width of the accepted-row counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin job; sampled only in IDLE
- w_in1, w_in2, w_in3, w_in4  input  DATA_W each  weights for PE(0,0), PE(0,1), PE(1,0), PE(1,1); sampled with start
- act_valid  input  1  activation beat present
- act_ready  output  1  feeder accepts beat
- act_a1  input  DATA_W  activation for array row 0
- act_a2  input  DATA_W  activation for array row 1
- act_last  input  1  marks final beat of job
- load_weight  output  1  weight-load strobe to array
- weight1, weight2, weight3, weight4  output  DATA_W each  registered weights
- valid  output  1  array input valid
- a_in1  output  DATA_W  skewed row-0 activation
- a_in2  output  DATA_W  skewed row-1 activation
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle completion pulse
- row_count  output  CNT_W  beats accepted in current job

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: weights, a_in1/a_in2, valid, load_weight, act_ready, done, busy, row_count.
  - Skew pipeline is cleared.
  - Reset mid-job abandons the job with no done pulse.
- State machine is IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start=1 at edge T, w_in1..4 are registered onto weight1..4 and row_count is cleared; go to LOAD_W.
  - start is ignored in every other state.
- LOAD_W: lasts exactly one cycle.
  - load_weight=1 during the cycle after T; weight1..4 are stable in that cycle and held until the next start or reset.
  - Go to STREAM.
- STREAM:
  - act_ready=1 combinationally from state.
  - A beat is accepted on an edge where act_valid & act_ready.
  - Each accepted beat increments row_count; the counter wraps modulo 2^CNT_W with no flag.
  - If the accepted beat has act_last=1, go to DRAIN; act_ready drops in the next cycle.
- Skew pipeline:
  - Lane 1: beat accepted at edge E appears on a_in1 in cycle E+1.
  - Lane 2: act_a2 of the same beat is delayed one extra register and appears on a_in2 in cycle E+2.
  - Each lane carries its own valid bit. A lane with no data, including a bubble cycle where act_valid=0, drives 0.
  - Output `valid` = lane1_vld | lane2_vld. Bubbles propagate skewed exactly like data.
- DRAIN: one cycle, during which lane 2 emits the last beat's act_a2 and a_in1=0. Go to DONE.
- DONE: done=1 for one cycle. valid=0, a_in1=a_in2=0, act_ready=0. Return to IDLE.
- busy=1 in LOAD_W, STREAM, DRAIN and DONE.
- Simultaneous events:
  - act_last on the first beat is legal: single-row job.
  - act_valid outside STREAM is ignored and not consumed.
- No arithmetic besides the counter. Data passes unmodified at DATA_W bits.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset=0 mid-stream after 2 beats, then release.
  - Required: all outputs 0; done never pulses; next start works normally.
- Weight load:
  - Stimulus: start with w_in1..4=1,2,3,4.
  - Required: load_weight high exactly one cycle (the cycle after start); weight1..4=1,2,3,4 in that cycle and held afterwards; act_ready rises the following cycle.
- Two-row job, no bubbles:
  - Stimulus: beats (a1,a2)=(5,6) then (7,8,last).
  - Required, cycle by cycle after first acceptance: a_in1 = 5, 7, 0, 0; a_in2 = 0, 6, 8, 0; valid = 1, 1, 1, 0.
  - Required: done pulses one cycle after the DRAIN cycle; row_count=2.
- Bubble:
  - Stimulus: beats (1,2), idle cycle, (3,4,last).
  - Required: a_in1 = 1, 0, 3; a_in2 = 0, 2, 0, 4; valid stays 1 through the bubble because lane 2 is active.
- Single-row job:
  - Stimulus: one beat (9,10,last).
  - Required: a_in1=9 then a_in2=10 one cycle later; done pulse; busy falls to 0 afterwards.
- Start ignored while busy:
  - Stimulus: pulse start with w_in=0xFFFF during STREAM.
  - Required: weights unchanged; no second load_weight pulse.

Source files
------------

// File: rtl/mmu_feeder.sv
// Feeder for the 2x2 systolic array: latches the weight set, strobes load_weight,
// then streams activation row-pairs with lane 2 skewed one cycle behind lane 1.
module mmu_feeder #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] w_in1,
    input  logic [DATA_W-1:0] w_in2,
    input  logic [DATA_W-1:0] w_in3,
    input  logic [DATA_W-1:0] w_in4,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [DATA_W-1:0] act_a1,
    input  logic [DATA_W-1:0] act_a2,
    input  logic              act_last,
    output logic              load_weight,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] weight4,
    output logic              valid,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  row_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              last_seen_r;
    logic [DATA_W-1:0] a2_dly_r;
    logic              a2_vld_dly_r;
    logic              accept_s;

    // The last beat leaves one more cycle for lane 1 to show it; ready is held low meanwhile.
    assign act_ready = (state_r == STREAM) && !last_seen_r;
    assign accept_s  = act_valid && act_ready;

    // Next-state selection for the job sequencer.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD_W;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_W: state_nxt_s = STREAM;
            STREAM: begin
                if (last_seen_r) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, registered control outputs, weight capture, row counter and skew lanes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_seen_r  <= 1'b0;
            load_weight  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            weight1      <= {DATA_W{1'b0}};
            weight2      <= {DATA_W{1'b0}};
            weight3      <= {DATA_W{1'b0}};
            weight4      <= {DATA_W{1'b0}};
            row_count    <= {CNT_W{1'b0}};
            a_in1        <= {DATA_W{1'b0}};
            a2_dly_r     <= {DATA_W{1'b0}};
            a2_vld_dly_r <= 1'b0;
            a_in2        <= {DATA_W{1'b0}};
            valid        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            load_weight <= (state_nxt_s == LOAD_W);
            busy        <= (state_nxt_s != IDLE);
            done        <= (state_nxt_s == DONE);

            if ((state_r == IDLE) && start) begin
                weight1     <= w_in1;
                weight2     <= w_in2;
                weight3     <= w_in3;
                weight4     <= w_in4;
                row_count   <= {CNT_W{1'b0}};
                last_seen_r <= 1'b0;
            end else if (accept_s) begin
                row_count   <= row_count + {{(CNT_W-1){1'b0}}, 1'b1};
                last_seen_r <= act_last;
            end else if (state_r != STREAM) begin
                last_seen_r <= 1'b0;
            end else begin
                last_seen_r <= last_seen_r;
            end

            a_in1        <= accept_s ? act_a1 : {DATA_W{1'b0}};
            a2_dly_r     <= accept_s ? act_a2 : {DATA_W{1'b0}};
            a2_vld_dly_r <= accept_s;
            a_in2        <= a2_dly_r;
            valid        <= accept_s || a2_vld_dly_r;
        end
    end

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder: inputs change and outputs are checked on the falling edge.
module tb_mmu_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] w_in1, w_in2, w_in3, w_in4;
    logic        act_valid;
    logic        act_ready;
    logic [15:0] act_a1, act_a2;
    logic        act_last;
    logic        load_weight;
    logic [15:0] weight1, weight2, weight3, weight4;
    logic        valid;
    logic [15:0] a_in1, a_in2;
    logic        busy;
    logic        done;
    logic [7:0]  row_count;

    int errors = 0;
    int checks = 0;

    mmu_feeder #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_in1(w_in1), .w_in2(w_in2), .w_in3(w_in3), .w_in4(w_in4),
        .act_valid(act_valid), .act_ready(act_ready),
        .act_a1(act_a1), .act_a2(act_a2), .act_last(act_last),
        .load_weight(load_weight),
        .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
        .valid(valid), .a_in1(a_in1), .a_in2(a_in2),
        .busy(busy), .done(done), .row_count(row_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic beat(input logic v, input logic [15:0] a1, input logic [15:0] a2, input logic l);
        act_valid = v;
        act_a1    = a1;
        act_a2    = a2;
        act_last  = l;
    endtask

    task automatic lanes(input string tag, input logic [15:0] e1, input logic [15:0] e2, input logic ev);
        check_eq({tag, ".a_in1"}, {16'd0, a_in1}, {16'd0, e1});
        check_eq({tag, ".a_in2"}, {16'd0, a_in2}, {16'd0, e2});
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    // Pulses start from IDLE and returns in the first STREAM cycle.
    task automatic start_job(input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4);
        start = 1'b1;
        w_in1 = w1; w_in2 = w2; w_in3 = w3; w_in4 = w4;
        nx();
        start = 1'b0;
        nx();
    endtask

    task automatic all_zero(input string tag);
        check_eq({tag, ".lanes"}, {a_in1, a_in2}, 32'd0);
        check_eq({tag, ".ctl"}, {26'd0, valid, load_weight, act_ready, done, busy, 1'b0}, 32'd0);
        check_eq({tag, ".row_count"}, {24'd0, row_count}, 32'd0);
        check_eq({tag, ".weights"}, {weight1 | weight2, weight3 | weight4}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        w_in1 = 16'd0; w_in2 = 16'd0; w_in3 = 16'd0; w_in4 = 16'd0;
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        nx(); nx();
        all_zero("por");
        reset = 1'b1;
        nx();
        check_eq("idle.busy", {31'd0, busy}, 32'd0);

        // Reset mid-stream after two beats.
        start_job(16'd7, 16'd7, 16'd7, 16'd7);
        check_eq("rst.ready", {31'd0, act_ready}, 32'd1);
        beat(1'b1, 16'd11, 16'd12, 1'b0);
        nx();
        beat(1'b1, 16'd13, 16'd14, 1'b0);
        nx();
        check_eq("rst.pre_count", {24'd0, row_count}, 32'd2);
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        reset = 1'b0;
        #1;
        all_zero("rst.mid");
        for (int i = 0; i < 4; i++) begin
            nx();
            check_eq("rst.no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1;
        nx();
        for (int i = 0; i < 3; i++) begin
            nx();
            check_eq("rst.after_done", {31'd0, done}, 32'd0);
        end

        // Weight load and two-row job.
        start = 1'b1;
        w_in1 = 16'd1; w_in2 = 16'd2; w_in3 = 16'd3; w_in4 = 16'd4;
        nx();
        start = 1'b0;
        check_eq("wl.load", {31'd0, load_weight}, 32'd1);
        check_eq("wl.w12", {weight1, weight2}, {16'd1, 16'd2});
        check_eq("wl.w34", {weight3, weight4}, {16'd3, 16'd4});
        check_eq("wl.ready_lo", {31'd0, act_ready}, 32'd0);
        check_eq("wl.busy", {31'd0, busy}, 32'd1);
        w_in1 = 16'd0; w_in2 = 16'd0; w_in3 = 16'd0; w_in4 = 16'd0;
        nx();
        check_eq("wl.load_off", {31'd0, load_weight}, 32'd0);
        check_eq("wl.ready_hi", {31'd0, act_ready}, 32'd1);
        check_eq("wl.hold", {weight1, weight4}, {16'd1, 16'd4});
        beat(1'b1, 16'd5, 16'd6, 1'b0);
        nx();
        lanes("two.c1", 16'd5, 16'd0, 1'b1);
        check_eq("two.cnt1", {24'd0, row_count}, 32'd1);
        beat(1'b1, 16'd7, 16'd8, 1'b1);
        nx();
        lanes("two.c2", 16'd7, 16'd6, 1'b1);
        check_eq("two.ready_drop", {31'd0, act_ready}, 32'd0);
        beat(1'b1, 16'd99, 16'd98, 1'b0);
        nx();
        lanes("two.c3", 16'd0, 16'd8, 1'b1);
        check_eq("two.no_done_drain", {31'd0, done}, 32'd0);
        nx();
        lanes("two.c4", 16'd0, 16'd0, 1'b0);
        check_eq("two.done", {31'd0, done}, 32'd1);
        check_eq("two.busy_done", {31'd0, busy}, 32'd1);
        nx();
        check_eq("two.done_off", {31'd0, done}, 32'd0);
        check_eq("two.idle", {31'd0, busy}, 32'd0);
        check_eq("two.count", {24'd0, row_count}, 32'd2);
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        nx();
        check_eq("two.ignored", {31'd0, valid}, 32'd0);

        // Bubble job, with a start pulse attempted mid-stream.
        start_job(16'd1, 16'd2, 16'd3, 16'd4);
        beat(1'b1, 16'd1, 16'd2, 1'b0);
        nx();
        lanes("bub.c1", 16'd1, 16'd0, 1'b1);
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        start = 1'b1;
        w_in1 = 16'hFFFF; w_in2 = 16'hFFFF; w_in3 = 16'hFFFF; w_in4 = 16'hFFFF;
        nx();
        start = 1'b0;
        lanes("bub.c2", 16'd0, 16'd2, 1'b1);
        check_eq("ign.load", {31'd0, load_weight}, 32'd0);
        beat(1'b1, 16'd3, 16'd4, 1'b1);
        nx();
        lanes("bub.c3", 16'd3, 16'd0, 1'b1);
        check_eq("ign.load2", {31'd0, load_weight}, 32'd0);
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        nx();
        lanes("bub.c4", 16'd0, 16'd4, 1'b1);
        nx();
        lanes("bub.c5", 16'd0, 16'd0, 1'b0);
        check_eq("bub.done", {31'd0, done}, 32'd1);
        check_eq("ign.w12", {weight1, weight2}, {16'd1, 16'd2});
        check_eq("ign.w34", {weight3, weight4}, {16'd3, 16'd4});
        nx();
        check_eq("bub.count", {24'd0, row_count}, 32'd2);

        // Single-row job.
        start_job(16'd5, 16'd6, 16'd7, 16'd8);
        beat(1'b1, 16'd9, 16'd10, 1'b1);
        nx();
        lanes("one.c1", 16'd9, 16'd0, 1'b1);
        beat(1'b0, 16'd0, 16'd0, 1'b0);
        nx();
        lanes("one.c2", 16'd0, 16'd10, 1'b1);
        nx();
        check_eq("one.done", {31'd0, done}, 32'd1);
        lanes("one.c3", 16'd0, 16'd0, 1'b0);
        nx();
        check_eq("one.done_off", {31'd0, done}, 32'd0);
        check_eq("one.busy_off", {31'd0, busy}, 32'd0);
        check_eq("one.count", {24'd0, row_count}, 32'd1);
        check_eq("one.w", {weight1, weight4}, {16'd5, 16'd8});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
